// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state encoding and default timing for the PC control sequencer
package pc_ctrl_pkg;

    // Stage order follows the reset-release sequence: all held, clk released,
    // cpu released, fully running, start pulse in flight.
    typedef enum logic [2:0] {
        S_ALL    = 3'd0,
        S_CLKREL = 3'd1,
        S_CPUREL = 3'd2,
        S_READY  = 3'd3,
        S_START  = 3'd4
    } seq_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES     = 25;
    localparam int DEF_START_LEN       = 25;
    localparam int DEF_CNT_W           = 16;

    // A timing parameter of 0 would make "count to N-1" meaningless; run it as 1.
    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer followed by a stability-count debouncer
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   raw    in  raw button/switch level, asynchronous to clk
//   level  out debounced level, resets to 0
module btn_debounce
    import pc_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int               DEB_EFF = clamp1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEB_EFF - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with the
    // current level; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/pc_ctrl_sequencer.sv
// rtl/pc_ctrl_sequencer.sv - staged reset release and start-pulse generator for the PC CPU top
//
// Ports:
//   boardCLK       in  system clock, rising edge
//   board_reset_n  in  asynchronous active-low reset
//   btn_reset      in  raw reset push-button (active-high)
//   btn_start      in  raw start push-button (active-high)
//   sw_enable      in  raw enable switch
//   clk_reset      out clock-domain reset to PC (active-high)
//   cpu_reset      out CPU reset to PC (active-high)
//   mem_reset      out memory reset to PC (active-high)
//   enable         out debounced sw_enable
//   start          out fixed-length start pulse
//   ready          out sequence complete and no pulse in flight
module pc_ctrl_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int START_LEN       = DEF_START_LEN,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic boardCLK,
    input  logic board_reset_n,
    input  logic btn_reset,
    input  logic btn_start,
    input  logic sw_enable,
    output logic clk_reset,
    output logic cpu_reset,
    output logic mem_reset,
    output logic enable,
    output logic start,
    output logic ready
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(clamp1(HOLD_CYCLES) - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(clamp1(START_LEN) - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic db_reset, db_start, db_enable;
    logic db_reset_q, db_start_q;
    logic rst_edge, start_edge;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_reset (
        .clk(boardCLK), .rst_n(board_reset_n), .raw(btn_reset), .level(db_reset)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
        .clk(boardCLK), .rst_n(board_reset_n), .raw(btn_start), .level(db_start)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enable (
        .clk(boardCLK), .rst_n(board_reset_n), .raw(sw_enable), .level(db_enable)
    );

    // Registered rising-edge detect: a held button yields exactly one edge.
    always_ff @(posedge boardCLK or negedge board_reset_n) begin
        if (!board_reset_n) begin
            db_reset_q <= 1'b0;
            db_start_q <= 1'b0;
            rst_edge   <= 1'b0;
            start_edge <= 1'b0;
            enable     <= 1'b0;
        end else begin
            db_reset_q <= db_reset;
            db_start_q <= db_start;
            rst_edge   <= db_reset & ~db_reset_q;
            start_edge <= db_start & ~db_start_q;
            enable     <= db_enable;
        end
    end

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             clk_reset_nx, cpu_reset_nx, mem_reset_nx, start_nx, ready_nx;

    // State register, shared stage counter and registered Moore outputs.
    always_ff @(posedge boardCLK or negedge board_reset_n) begin
        if (!board_reset_n) begin
            state     <= S_ALL;
            cnt       <= '0;
            clk_reset <= 1'b1;
            cpu_reset <= 1'b1;
            mem_reset <= 1'b1;
            start     <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state     <= state_next;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + ONE;
            end
            clk_reset <= clk_reset_nx;
            cpu_reset <= cpu_reset_nx;
            mem_reset <= mem_reset_nx;
            start     <= start_nx;
            ready     <= ready_nx;
        end
    end

    // Next state. A reset edge overrides everything, including a coincident
    // start edge, and restarts the count even when already in S_ALL.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        if (rst_edge) begin
            state_next = S_ALL;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                S_ALL:    if (cnt == HOLD_LAST)  state_next = S_CLKREL;
                S_CLKREL: if (cnt == HOLD_LAST)  state_next = S_CPUREL;
                S_CPUREL: if (cnt == HOLD_LAST)  state_next = S_READY;
                S_READY:  if (start_edge)        state_next = S_START;
                S_START:  if (cnt == START_LAST) state_next = S_READY;
                default:                         state_next = S_ALL;
            endcase
            if (state_next != state) cnt_clr = 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered outputs
    // change on the same edge as the state itself.
    always_comb begin
        clk_reset_nx = 1'b0;
        cpu_reset_nx = 1'b0;
        mem_reset_nx = 1'b0;
        start_nx     = 1'b0;
        ready_nx     = 1'b0;
        case (state_next)
            S_ALL: begin
                clk_reset_nx = 1'b1;
                cpu_reset_nx = 1'b1;
                mem_reset_nx = 1'b1;
            end
            S_CLKREL: begin
                cpu_reset_nx = 1'b1;
                mem_reset_nx = 1'b1;
            end
            S_CPUREL: mem_reset_nx = 1'b1;
            S_READY:  ready_nx     = 1'b1;
            S_START:  start_nx     = 1'b1;
            default: begin
                clk_reset_nx = 1'b1;
                cpu_reset_nx = 1'b1;
                mem_reset_nx = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_ctrl_sequencer.sv
// tb/tb_pc_ctrl_sequencer.sv - table-driven and randomized self-checking bench for pc_ctrl_sequencer
module tb_pc_ctrl_sequencer;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int SLEN = 4;

    logic boardCLK      = 1'b0;
    logic board_reset_n = 1'b0;
    logic btn_reset     = 1'b0;
    logic btn_start     = 1'b0;
    logic sw_enable     = 1'b0;
    logic clk_reset, cpu_reset, mem_reset, enable, start, ready;

    pc_ctrl_sequencer #(
        .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .START_LEN(SLEN), .CNT_W(16)
    ) dut (
        .boardCLK(boardCLK), .board_reset_n(board_reset_n),
        .btn_reset(btn_reset), .btn_start(btn_start), .sw_enable(sw_enable),
        .clk_reset(clk_reset), .cpu_reset(cpu_reset), .mem_reset(mem_reset),
        .enable(enable), .start(start), .ready(ready)
    );

    always #5 boardCLK = ~boardCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: raw input history per channel, debounced levels, and the
    // sequence expressed as "cycles since sequence start" plus "pulse cycles left".
    bit raw_at [3][64];
    bit lev    [3];
    bit lev_d  [3];
    bit rise_rst, rise_st, m_enable;
    int t_edge, seq_t, pulse;

    function automatic bit samp_at(input int ch, input int tt);
        if (tt <= 2) return 1'b0;
        return raw_at[ch][(tt - 2) % 64];
    endfunction

    function automatic bit [5:0] model_out();
        bit [5:0] o;
        o[5] = (seq_t < HOLD);
        o[4] = (seq_t < 2 * HOLD);
        o[3] = (seq_t < 3 * HOLD);
        o[2] = m_enable;
        o[1] = (pulse > 0);
        o[0] = (seq_t >= 3 * HOLD) && (pulse == 0);
        return o;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            lev[ch] = 1'b0;
            lev_d[ch] = 1'b0;
        end
        rise_rst = 1'b0; rise_st = 1'b0; m_enable = 1'b0;
        t_edge = 0; seq_t = 0; pulse = 0;
    endtask

    task automatic model_step(input bit r0, input bit r1, input bit r2);
        bit r [3];
        bit all_diff;
        r[0] = r0; r[1] = r1; r[2] = r2;
        if (rise_rst) begin
            seq_t = 0;
            pulse = 0;
        end else if (pulse > 0) begin
            pulse--;
        end else if (seq_t >= 3 * HOLD) begin
            if (rise_st) pulse = SLEN;
        end else begin
            seq_t++;
        end
        m_enable = lev[2];
        rise_rst = lev[0] & ~lev_d[0];
        rise_st  = lev[1] & ~lev_d[1];
        t_edge++;
        for (int ch = 0; ch < 3; ch++) begin
            raw_at[ch][t_edge % 64] = r[ch];
            lev_d[ch] = lev[ch];
            all_diff = (t_edge >= DEB);
            for (int k = 0; k < DEB; k++)
                if (samp_at(ch, t_edge - k) == lev[ch]) all_diff = 1'b0;
            if (all_diff) lev[ch] = ~lev[ch];
        end
    endtask

    function automatic bit [5:0] dut_out();
        return {clk_reset, cpu_reset, mem_reset, enable, start, ready};
    endfunction

    task automatic check(input string name, input bit [5:0] want);
        checks++;
        if (dut_out() !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %b want %b (clk,cpu,mem,en,start,ready)",
                     name, $time, dut_out(), want);
        end
    endtask

    task automatic tick();
        bit r0, r1, r2;
        r0 = btn_reset; r1 = btn_start; r2 = sw_enable;
        @(posedge boardCLK);
        if (board_reset_n) model_step(r0, r1, r2);
        else model_reset();
        @(negedge boardCLK);
        check("model", model_out());
    endtask

    typedef struct {
        bit       b_rst;
        bit       b_st;
        bit       sw;
        int       n;
        bit [5:0] want;
        string    name;
    } vec_t;

    vec_t vecs [$];

    initial begin
        // {btn_reset, btn_start, sw_enable, cycles, expected {clk,cpu,mem,en,start,ready}, name}
        vecs.push_back('{0, 0, 0, 7,  6'b111000, "hold_all"});
        vecs.push_back('{0, 0, 0, 1,  6'b011000, "clk_rel_8"});
        vecs.push_back('{0, 0, 0, 7,  6'b011000, "clk_rel_hold"});
        vecs.push_back('{0, 0, 0, 1,  6'b001000, "cpu_rel_16"});
        vecs.push_back('{0, 0, 0, 7,  6'b001000, "cpu_rel_hold"});
        vecs.push_back('{0, 0, 0, 1,  6'b000001, "ready_24"});
        vecs.push_back('{0, 1, 0, 7,  6'b000001, "start_latency"});
        vecs.push_back('{0, 1, 0, 1,  6'b000010, "start_rise_8"});
        vecs.push_back('{0, 1, 0, 2,  6'b000010, "start_mid"});
        vecs.push_back('{0, 0, 0, 1,  6'b000010, "start_4th"});
        vecs.push_back('{0, 0, 0, 1,  6'b000001, "start_end"});
        vecs.push_back('{0, 0, 0, 20, 6'b000001, "one_pulse"});
        vecs.push_back('{0, 1, 0, 2,  6'b000001, "glitch_hi"});
        vecs.push_back('{0, 0, 0, 20, 6'b000001, "glitch_no_pulse"});
        vecs.push_back('{0, 0, 1, 6,  6'b000001, "en_wait"});
        vecs.push_back('{0, 0, 1, 1,  6'b000101, "en_on"});
        vecs.push_back('{1, 0, 1, 7,  6'b000101, "rst_latency"});
        vecs.push_back('{1, 0, 1, 1,  6'b111100, "rst_all"});
        vecs.push_back('{0, 0, 1, 8,  6'b011100, "seq1_clk"});
        vecs.push_back('{0, 0, 1, 8,  6'b001100, "seq1_cpu"});
        vecs.push_back('{1, 0, 1, 7,  6'b001100, "cpurel_press"});
        vecs.push_back('{1, 0, 1, 1,  6'b111100, "cpurel_rst"});
        vecs.push_back('{0, 0, 1, 7,  6'b111100, "seq2_all"});
        vecs.push_back('{0, 0, 1, 1,  6'b011100, "seq2_clk"});
        vecs.push_back('{0, 0, 1, 8,  6'b001100, "seq2_cpu"});
        vecs.push_back('{0, 0, 1, 8,  6'b000101, "seq2_ready"});
        vecs.push_back('{1, 1, 1, 7,  6'b000101, "both_wait"});
        vecs.push_back('{1, 1, 1, 1,  6'b111100, "both_rst_wins"});
        vecs.push_back('{0, 0, 1, 24, 6'b000101, "both_seq_ready"});
        vecs.push_back('{0, 1, 1, 8,  6'b000110, "start_again"});

        model_reset();
        repeat (3) tick();
        check("reset_state", 6'b111000);
        board_reset_n = 1'b1;

        foreach (vecs[i]) begin
            btn_reset = vecs[i].b_rst;
            btn_start = vecs[i].b_st;
            sw_enable = vecs[i].sw;
            repeat (vecs[i].n) tick();
            check(vecs[i].name, vecs[i].want);
        end

        // Mid-pulse board reset: outputs must change without waiting for an edge.
        check("pulse_before_async", 6'b000110);
        board_reset_n = 1'b0;
        #1;
        check("async_reset", 6'b111000);
        model_reset();
        btn_start = 1'b0;
        sw_enable = 1'b0;
        @(negedge boardCLK);
        tick();
        board_reset_n = 1'b1;

        // Randomized phase against the model.
        for (int it = 0; it < 400; it++) begin
            btn_reset = ($urandom_range(0, 11) == 0);
            btn_start = $urandom_range(0, 1);
            sw_enable = $urandom_range(0, 1);
            if ($urandom_range(0, 60) == 0) begin
                board_reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                board_reset_n = 1'b1;
            end
            repeat ($urandom_range(1, 12)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
